// File: rtl/sram_arbiter.sv
// sram_arbiter: fetch/data arbiter onto one single-port sync SRAM with starvation guard and 1-cycle read routing
module sram_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [3:0]  d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic [3:0]  m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} own_t;
    own_t          own_q, own_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          force_i;
    always_comb begin
        force_i  = starve_q == CW'(STARVE_MAX);
        d_gnt    = !rst && d_req && !(i_req && force_i);
        i_gnt    = !rst && i_req && (!d_req || force_i);
        m_en     = i_gnt | d_gnt;
        m_addr   = d_gnt ? d_addr : i_gnt ? i_addr : '0;
        m_wen    = d_gnt ? d_wen : '0;
        m_wdata  = d_gnt ? d_wdata : '0;
        starve_d = (d_gnt && i_req) ? starve_q + CW'(1) : '0;
        own_d    = (i_gnt && !i_flush) ? OWN_I : (d_gnt && d_wen == 4'b0000) ? OWN_D : OWN_NONE;
        i_rvalid = !rst && own_q == OWN_I && !i_flush;
        d_rvalid = !rst && own_q == OWN_D;
        i_rdata  = m_rdata;
        d_rdata  = m_rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            own_q    <= OWN_NONE;
        end else begin
            starve_q <= starve_d;
            own_q    <= own_d;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random checks of sram_arbiter against a cycle-level reference model
module tb_sram_arbiter;
    localparam int SMAX = 3;
    logic        clk = 1'b0, rst = 1'b1;
    logic        i_req = 1'b0, i_flush = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [3:0]  d_wen = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_wen;
    int checks = 0, passed = 0;
    int streak = 0, pend = 0;
    sram_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic step(input logic r, input logic ir, input logic [31:0] ia, input logic fl,
                        input logic dr, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                        input logic [31:0] md);
        int eg;
        @(negedge clk);
        rst = r; i_req = ir; i_addr = ia; i_flush = fl;
        d_req = dr; d_wen = dw; d_addr = da; d_wdata = dd; m_rdata = md;
        #1;
        // 0 = nobody, 1 = fetch, 2 = data; data wins unless fetch has waited SMAX data grants
        eg = r ? 0 : (dr && !(ir && streak >= SMAX)) ? 2 : ir ? 1 : 0;
        chk("i_gnt", 32'(i_gnt), 32'(eg == 1));
        chk("d_gnt", 32'(d_gnt), 32'(eg == 2));
        chk("m_en", 32'(m_en), 32'(eg != 0));
        chk("m_addr", m_addr, eg == 1 ? ia : eg == 2 ? da : 32'h0);
        chk("m_wen", 32'(m_wen), eg == 2 ? 32'(dw) : 32'h0);
        chk("m_wdata", m_wdata, eg == 2 ? dd : 32'h0);
        chk("i_rvalid", 32'(i_rvalid), 32'(!r && pend == 1 && !fl));
        chk("d_rvalid", 32'(d_rvalid), 32'(!r && pend == 2));
        chk("i_rdata", i_rdata, md);
        chk("d_rdata", d_rdata, md);
        chk("starve_cnt", 32'(dut.starve_q), 32'(streak));
        @(posedge clk);
        if (r) begin
            streak = 0;
            pend = 0;
        end else begin
            pend = (eg == 1 && !fl) ? 1 : (eg == 2 && dw == 4'b0000) ? 2 : 0;
            streak = (eg == 2 && ir) ? streak + 1 : 0;
        end
    endtask
    initial begin
        step(1, 1, 32'h44, 0, 1, 4'h0, 32'h88, 32'h1, 32'hA5A5A5A5);
        step(1, 1, 32'h44, 1, 1, 4'hF, 32'h88, 32'h2, 32'h5A5A5A5A);
        // fetch only, then its response
        step(0, 1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h24020005);
        // data write: no read response afterwards
        step(0, 0, 32'h0, 0, 1, 4'b0011, 32'h2000, 32'hDEADBEEF, 32'h0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h11111111);
        // both requesting reads: d,d,d,i,d
        for (int k = 0; k < 5; k++)
            step(0, 1, 32'h300, 0, 1, 4'h0, 32'h4000, 32'h0, 32'hC0DE0000 + 32'(k));
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'hC0DE0005);
        // fetch grant then flush while a data read is granted
        step(0, 1, 32'h500, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
        step(0, 0, 32'h0, 1, 1, 4'h0, 32'h6000, 32'h0, 32'h12345678);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h9ABCDEF0);
        // reset right after a data read grant
        step(0, 0, 32'h0, 0, 1, 4'h0, 32'h7000, 32'h0, 32'h0);
        step(1, 1, 32'h0, 0, 1, 4'h0, 32'h7000, 32'h0, 32'h13579BDF);
        step(0, 1, 32'h800, 0, 0, 4'h0, 32'h0, 32'h0, 32'h2468ACE0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0F0F0F0F);
        // alternating fetch/data reads
        for (int k = 0; k < 8; k++)
            step(0, k % 2 == 0, 32'h900 + 32'(k * 4), 0, k % 2 == 1, 4'h0, 32'hA00 + 32'(k * 4), 32'h0,
                 32'hBEEF0000 + 32'(k));
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 32'hBEEF0008);
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1 ? 4'($urandom) : 4'h0,
                 $urandom, $urandom, $urandom);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: i_req  input  1  instruction-fetch read request; i_addr  input  32  fetch byte address.
REQ-004 SHALL have ports: i_gnt  output  1  fetch request accepted this cycle; i_rvalid  output  1  fetch data valid; i_rdata  output  32  fetch data.
REQ-005 SHALL have ports: i_flush  input  1  discard the in-flight fetch response.
REQ-006 SHALL have ports: d_req  input  1  data request; d_wen  input  4  byte write strobes, 0000 = read; d_addr  input  32; d_wdata  input  32.
REQ-007 SHALL have ports: d_gnt  output  1  data request accepted; d_rvalid  output  1  data read valid; d_rdata  output  32.
REQ-008 SHALL have ports: m_en  output  1; m_wen  output  4; m_addr  output  32; m_wdata  output  32  to single-port synchronous SRAM; m_rdata  input  32  valid the cycle after m_en.
REQ-009 SHALL have parameter STARVE_MAX, default 3, meaning the maximum number of consecutive data grants while i_req is held before the fetch is forced through.

Function
REQ-010 SHALL grant at most one requester per cycle; i_gnt and d_gnt SHALL be combinational from the current requests and state.
REQ-011 SHALL grant data over fetch when both request, unless starve_cnt == STARVE_MAX, in which case fetch SHALL be granted.
REQ-012 SHALL hold a starvation counter starve_cnt of width clog2(STARVE_MAX+1).
- SHALL increment on a d_gnt cycle with i_req=1.
- SHALL clear on any i_gnt cycle, or any cycle with i_req=0.
- SHALL hold otherwise.
- SHALL never exceed STARVE_MAX.
REQ-013 SHALL drive the SRAM port from the grantee, combinationally:
- m_en = i_gnt|d_gnt.
- fetch grant: m_addr=i_addr, m_wen=0000, m_wdata=0.
- data grant: m_addr=d_addr, m_wen=d_wen, m_wdata=d_wdata.
- no grant: all m_* = 0.
REQ-014 SHALL register the owner of each granted read (none/inst/data) for one cycle; the read-response latency is exactly 1 cycle after the grant.
REQ-015 SHALL assert i_rvalid for exactly one cycle, the cycle after an i_gnt, unless i_flush was high in the grant cycle or in the response cycle.
REQ-016 SHALL assert d_rvalid for exactly one cycle, the cycle after a d_gnt with d_wen=0000; data writes SHALL produce no d_rvalid, and d_gnt is their completion.
REQ-017 SHALL pass m_rdata unmodified to i_rdata and d_rdata; their contents are meaningful only while the corresponding rvalid is high.
REQ-018 SHALL sustain back-to-back grants every cycle, so a response and a new grant may coincide in the same cycle.
REQ-019 SHALL NOT let i_flush affect data requests, grants or starve_cnt.
REQ-020 SHALL require requesters to hold req/addr/wen/wdata stable until their grant; a request dropped before grant is simply not serviced.

Reset
REQ-021 SHALL, on a rising edge with rst=1, clear starve_cnt to 0 and the response owner to none.
REQ-022 SHALL hold i_gnt, d_gnt, i_rvalid, d_rvalid and all m_* at 0 while rst=1.
REQ-023 SHALL keep i_rdata and d_rdata equal to m_rdata during reset.
REQ-024 SHALL, when rst is raised mid-transaction, suppress the pending rvalid on the following cycle.
REQ-025 SHALL make the first grant possible in the first cycle with rst=0.

Verification
REQ-026 SHALL cover: i_req=1 only, i_addr=0x00000100, m_rdata=0x24020005 next cycle -> i_gnt=1, m_en=1, m_addr=0x100, m_wen=0; next cycle i_rvalid=1, i_rdata=0x24020005.
REQ-027 SHALL cover: d_req=1, d_wen=0011, d_addr=0x2000, d_wdata=0xDEADBEEF -> d_gnt=1, m_wen=0011, m_wdata=0xDEADBEEF; no d_rvalid next cycle.
REQ-028 SHALL cover: i_req and d_req held high with data reads (STARVE_MAX=3) -> d_gnt in cycles 1-3, i_gnt in cycle 4, d_gnt in cycle 5; each rvalid goes to the correct owner one cycle after its grant.
REQ-029 SHALL cover: i_gnt in cycle t, i_flush=1 in cycle t+1 -> i_rvalid=0 in t+1; a simultaneous d_gnt in t+1 proceeds and d_rvalid=1 in t+2.
REQ-030 SHALL cover: d_gnt (read) in cycle t, rst=1 in cycle t+1 -> d_rvalid=0 in t+1 and t+2, starve_cnt=0, and a grant is possible in the first cycle after rst falls.
REQ-031 SHALL cover: 8 consecutive alternating i/d reads with distinct m_rdata values -> one grant per cycle and every response matched to its requester with 1-cycle latency.
